frame_buffer_arbiter: RTL and testbench
=======================================

FRAME_BUFFER_ARBITER -- requirements
Module: frame_buffer_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, the AXI byte-address width.
REQ-002 SHALL have parameter BURST_BYTES, default 8192, the bytes per burst (256 beats x 32 B).
REQ-003 SHALL have parameter FRAME_BURSTS, default 1024, the bursts per frame (minimum 2).
REQ-004 SHALL have parameter BASE_A, default 32'h0000_0000, the buffer A base address.
REQ-005 SHALL have parameter BASE_B, default 32'h0100_0000, the buffer B base address.
REQ-006 SHALL have port axi_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 SHALL have port rstn, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port wr_req, input, 1 bit: the capture side has a full burst buffered (FIFO occupancy).
REQ-009 SHALL have port wr_done, input, 1 bit: one-cycle pulse on write burst completion (B response).
REQ-010 SHALL have port rd_req, input, 1 bit: the readout side can accept a burst.
REQ-011 SHALL have port rd_done, input, 1 bit: one-cycle pulse when the last read beat (rlast) is accepted.
REQ-012 SHALL have port wr_grant, output, 1 bit: the write master owns the DDR port.
REQ-013 SHALL have port rd_grant, output, 1 bit: the read master owns the DDR port.
REQ-014 SHALL have port wr_addr, output, ADDR_WIDTH bits: the burst start address for the write master.
REQ-015 SHALL have port rd_addr, output, ADDR_WIDTH bits: the burst start address for the read master.
REQ-016 SHALL have port frame_ready, output, 1 bit: at least one complete frame has been published to the reader.
REQ-017 SHALL have port wr_buf_sel, output, 1 bit: the buffer being written (0=A, 1=B).
REQ-018 SHALL have port drop_cnt, output, 16 bits: the count of dropped write frames, saturating.

Function
REQ-019 SHALL implement an FSM with states IDLE, WR, RD; only one grant high at any time; grants are registered.
REQ-020 SHALL, in IDLE, go to WR next cycle if wr_req=1 only; go to RD if rd_req=1 and frame_ready=1 only; with both eligible, pick the master not served last (round-robin; last-served initialised to RD, so write wins first).
REQ-021 SHALL assert wr_grant/rd_grant in the first WR/RD cycle and hold it until the cycle after the matching done pulse; then return to IDLE, with a minimum of 1 IDLE cycle between grants.
REQ-022 SHALL keep wr_addr/rd_addr stable for the whole grant: wr_addr = base(wr_buf_sel) + wr_off*BURST_BYTES; rd_addr = base(rd_sel) + rd_off*BURST_BYTES.
REQ-023 SHALL, on wr_done in WR, increment wr_off; on reaching FRAME_BURSTS, wrap wr_off to 0 (frame complete).
REQ-024 SHALL, on frame complete with rd_off=0: set rd_sel to wr_buf_sel, toggle wr_buf_sel and set frame_ready=1 (publish).
REQ-025 SHALL, on frame complete with rd_off!=0 (reader mid-frame): leave both buffer selects unchanged (writer rewrites the same buffer) and increment drop_cnt, saturating at 16'hFFFF.
REQ-026 SHALL, on rd_done in RD, increment rd_off and wrap it to 0 at FRAME_BURSTS; the reader re-reads rd_sel until the next publish, so it never tears.
REQ-027 SHALL ignore wr_done/rd_done when not in the matching state, and ignore rd_req while frame_ready=0.
REQ-028 SHALL drop a requester's req mid-grant without effect: the grant persists until done.
REQ-029 SHALL guarantee the writer and reader buffers always differ once frame_ready=1.

Reset
REQ-030 SHALL, while rstn=0 (asynchronously), force: state IDLE, wr_grant=0, rd_grant=0, wr_off=0, rd_off=0, wr_buf_sel=0, rd_sel=1, frame_ready=0, drop_cnt=0, last-served=RD; hence wr_addr=BASE_A, rd_addr=BASE_B.
REQ-031 SHALL, on reset assertion mid-burst, drop the grant immediately; the attached masters are reset by the same rstn.

Verification (FRAME_BURSTS=4, BURST_BYTES=8192)
REQ-032 SHALL cover: after reset, wr_req=1 -> wr_grant next cycle, wr_addr=0x0; 4 wr_done pulses -> addrs 0x0, 0x2000, 0x4000, 0x6000, then frame_ready=1, wr_buf_sel=1, rd_addr=0x0, next wr_addr=0x0100_0000.
REQ-033 SHALL cover: rd_req=1 before any frame completes -> rd_grant stays 0.
REQ-034 SHALL cover: wr_req and rd_req both held, frame_ready=1 -> grants alternate WR, RD, WR, RD, each ending on its done pulse, never overlapping.
REQ-035 SHALL cover: the reader at rd_off=2 when the writer completes a frame -> drop_cnt=1, wr_buf_sel unchanged, rd_addr base unchanged.
REQ-036 SHALL cover: rstn pulsed low during a WR grant -> wr_grant=0 in the same cycle, all outputs at reset values, drop_cnt=0.
REQ-037 SHALL cover: a spurious rd_done in IDLE or WR -> rd_off unchanged.

Source files
------------

// File: rtl/frame_buffer_arbiter.sv
// frame_buffer_arbiter: round-robin DDR port arbiter for a double-buffered frame store
//   axi_clk/rstn          : clock, async active-low reset
//   wr_req/wr_done        : capture side burst ready / write burst complete pulse
//   rd_req/rd_done        : readout side burst wanted / read burst complete pulse
//   wr_grant/rd_grant     : registered ownership of the DDR port
//   wr_addr/rd_addr       : burst start addresses, stable for the whole grant
//   frame_ready           : a complete frame has been published to the reader
//   wr_buf_sel            : buffer being written (0=A, 1=B)
//   drop_cnt              : saturating count of write frames discarded
module frame_buffer_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int BURST_BYTES = 8192,
  parameter int FRAME_BURSTS = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_A = ADDR_WIDTH'(32'h0000_0000),
  parameter logic [ADDR_WIDTH-1:0] BASE_B = ADDR_WIDTH'(32'h0100_0000)
) (
  input  logic                  axi_clk,
  input  logic                  rstn,
  input  logic                  wr_req,
  input  logic                  wr_done,
  input  logic                  rd_req,
  input  logic                  rd_done,
  output logic                  wr_grant,
  output logic                  rd_grant,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  frame_ready,
  output logic                  wr_buf_sel,
  output logic [15:0]           drop_cnt
);
  localparam int OFF_W = FRAME_BURSTS > 1 ? $clog2(FRAME_BURSTS) : 1;
  typedef enum logic [1:0] {IDLE, WR, RD} state_t;
  state_t state;
  logic [OFF_W-1:0] wr_off, rd_off;
  logic rd_sel, last_rd;
  logic wr_last, rd_last, wr_elig, rd_elig;
  assign wr_last = wr_off == OFF_W'(FRAME_BURSTS - 1);
  assign rd_last = rd_off == OFF_W'(FRAME_BURSTS - 1);
  assign wr_elig = wr_req;
  assign rd_elig = rd_req && frame_ready;
  assign wr_addr = (wr_buf_sel ? BASE_B : BASE_A) + ADDR_WIDTH'(wr_off) * ADDR_WIDTH'(BURST_BYTES);
  assign rd_addr = (rd_sel ? BASE_B : BASE_A) + ADDR_WIDTH'(rd_off) * ADDR_WIDTH'(BURST_BYTES);
  always_ff @(posedge axi_clk or negedge rstn)
    if (!rstn) begin
      state       <= IDLE;
      wr_grant    <= 1'b0;
      rd_grant    <= 1'b0;
      wr_off      <= '0;
      rd_off      <= '0;
      wr_buf_sel  <= 1'b0;
      rd_sel      <= 1'b1;
      frame_ready <= 1'b0;
      drop_cnt    <= '0;
      last_rd     <= 1'b1;
    end else
      case (state)
        IDLE:
          if (wr_elig && (!rd_elig || last_rd)) begin
            state    <= WR;
            wr_grant <= 1'b1;
            last_rd  <= 1'b0;
          end else if (rd_elig) begin
            state    <= RD;
            rd_grant <= 1'b1;
            last_rd  <= 1'b1;
          end
        WR:
          if (wr_done) begin
            state    <= IDLE;
            wr_grant <= 1'b0;
            wr_off   <= wr_last ? '0 : wr_off + 1'b1;
            // Publishing is only safe at a reader frame boundary; otherwise the
            // writer overwrites its own buffer and the frame is counted as dropped.
            if (wr_last) begin
              if (rd_off == '0) begin
                rd_sel      <= wr_buf_sel;
                wr_buf_sel  <= ~wr_buf_sel;
                frame_ready <= 1'b1;
              end else if (drop_cnt != 16'hFFFF)
                drop_cnt <= drop_cnt + 16'd1;
            end
          end
        RD:
          if (rd_done) begin
            state    <= IDLE;
            rd_grant <= 1'b0;
            rd_off   <= rd_last ? '0 : rd_off + 1'b1;
          end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// tb_frame_buffer_arbiter: directed vector bench for frame_buffer_arbiter
module tb_frame_buffer_arbiter;
  logic axi_clk = 1'b0;
  logic rstn = 1'b0;
  logic wr_req = 1'b0, wr_done = 1'b0, rd_req = 1'b0, rd_done = 1'b0;
  logic wr_grant, rd_grant, frame_ready, wr_buf_sel;
  logic [31:0] wr_addr, rd_addr;
  logic [15:0] drop_cnt;
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic [3:0]  in;
    logic [1:0]  g;
    logic [31:0] wa;
    logic [31:0] ra;
    logic        fr;
    logic        sel;
    logic [15:0] drop;
  } vec_t;
  vec_t vecs[$];
  frame_buffer_arbiter #(
    .ADDR_WIDTH(32), .BURST_BYTES(8192), .FRAME_BURSTS(4)
  ) dut (
    .axi_clk(axi_clk), .rstn(rstn),
    .wr_req(wr_req), .wr_done(wr_done), .rd_req(rd_req), .rd_done(rd_done),
    .wr_grant(wr_grant), .rd_grant(rd_grant),
    .wr_addr(wr_addr), .rd_addr(rd_addr),
    .frame_ready(frame_ready), .wr_buf_sel(wr_buf_sel), .drop_cnt(drop_cnt)
  );
  always #5 axi_clk = ~axi_clk;
  task automatic chk(input string nm, input int idx, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", nm, idx, got, exp);
    end
  endtask
  task automatic chk_all(input int idx, input logic [1:0] g, input logic [31:0] wa, input logic [31:0] ra,
                         input logic fr, input logic sel, input logic [15:0] drop);
    chk("grants", idx, {30'd0, wr_grant, rd_grant}, {30'd0, g});
    chk("wr_addr", idx, wr_addr, wa);
    chk("rd_addr", idx, rd_addr, ra);
    chk("frame_ready", idx, {31'd0, frame_ready}, {31'd0, fr});
    chk("wr_buf_sel", idx, {31'd0, wr_buf_sel}, {31'd0, sel});
    chk("drop_cnt", idx, {16'd0, drop_cnt}, {16'd0, drop});
  endtask
  task automatic v(input logic [3:0] in, input logic [1:0] g, input logic [31:0] wa, input logic [31:0] ra,
                   input logic fr, input logic sel, input logic [15:0] drop);
    vec_t t;
    t.in = in; t.g = g; t.wa = wa; t.ra = ra; t.fr = fr; t.sel = sel; t.drop = drop;
    vecs.push_back(t);
  endtask
  initial begin
    // in = {wr_req, wr_done, rd_req, rd_done}; g = {wr_grant, rd_grant}
    v(4'b0010, 2'b00, 32'h0000_0000, 32'h0100_0000, 1'b0, 1'b0, 16'd0);
    v(4'b1010, 2'b10, 32'h0000_0000, 32'h0100_0000, 1'b0, 1'b0, 16'd0);
    v(4'b0010, 2'b10, 32'h0000_0000, 32'h0100_0000, 1'b0, 1'b0, 16'd0);
    v(4'b0111, 2'b00, 32'h0000_2000, 32'h0100_0000, 1'b0, 1'b0, 16'd0);
    v(4'b1011, 2'b10, 32'h0000_2000, 32'h0100_0000, 1'b0, 1'b0, 16'd0);
    v(4'b0110, 2'b00, 32'h0000_4000, 32'h0100_0000, 1'b0, 1'b0, 16'd0);
    v(4'b1010, 2'b10, 32'h0000_4000, 32'h0100_0000, 1'b0, 1'b0, 16'd0);
    v(4'b0110, 2'b00, 32'h0000_6000, 32'h0100_0000, 1'b0, 1'b0, 16'd0);
    v(4'b1010, 2'b10, 32'h0000_6000, 32'h0100_0000, 1'b0, 1'b0, 16'd0);
    v(4'b0110, 2'b00, 32'h0100_0000, 32'h0000_0000, 1'b1, 1'b1, 16'd0);
    v(4'b0010, 2'b01, 32'h0100_0000, 32'h0000_0000, 1'b1, 1'b1, 16'd0);
    v(4'b0011, 2'b00, 32'h0100_0000, 32'h0000_2000, 1'b1, 1'b1, 16'd0);
    v(4'b1010, 2'b10, 32'h0100_0000, 32'h0000_2000, 1'b1, 1'b1, 16'd0);
    v(4'b1110, 2'b00, 32'h0100_2000, 32'h0000_2000, 1'b1, 1'b1, 16'd0);
    v(4'b1010, 2'b01, 32'h0100_2000, 32'h0000_2000, 1'b1, 1'b1, 16'd0);
    v(4'b1011, 2'b00, 32'h0100_2000, 32'h0000_4000, 1'b1, 1'b1, 16'd0);
    v(4'b1010, 2'b10, 32'h0100_2000, 32'h0000_4000, 1'b1, 1'b1, 16'd0);
    v(4'b1110, 2'b00, 32'h0100_4000, 32'h0000_4000, 1'b1, 1'b1, 16'd0);
    v(4'b1000, 2'b10, 32'h0100_4000, 32'h0000_4000, 1'b1, 1'b1, 16'd0);
    v(4'b1100, 2'b00, 32'h0100_6000, 32'h0000_4000, 1'b1, 1'b1, 16'd0);
    v(4'b1000, 2'b10, 32'h0100_6000, 32'h0000_4000, 1'b1, 1'b1, 16'd0);
    v(4'b0100, 2'b00, 32'h0100_0000, 32'h0000_4000, 1'b1, 1'b1, 16'd1);
    v(4'b0010, 2'b01, 32'h0100_0000, 32'h0000_4000, 1'b1, 1'b1, 16'd1);
    v(4'b0001, 2'b00, 32'h0100_0000, 32'h0000_6000, 1'b1, 1'b1, 16'd1);
    v(4'b0010, 2'b01, 32'h0100_0000, 32'h0000_6000, 1'b1, 1'b1, 16'd1);
    v(4'b0001, 2'b00, 32'h0100_0000, 32'h0000_0000, 1'b1, 1'b1, 16'd1);
    repeat (2) @(posedge axi_clk);
    #1 chk_all(-1, 2'b00, 32'h0000_0000, 32'h0100_0000, 1'b0, 1'b0, 16'd0);
    @(negedge axi_clk) rstn = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge axi_clk);
      {wr_req, wr_done, rd_req, rd_done} = vecs[i].in;
      @(posedge axi_clk);
      #1 chk_all(i, vecs[i].g, vecs[i].wa, vecs[i].ra, vecs[i].fr, vecs[i].sel, vecs[i].drop);
    end
    // reset asserted in the middle of a write grant must clear everything at once
    @(negedge axi_clk);
    {wr_req, wr_done, rd_req, rd_done} = 4'b1000;
    @(posedge axi_clk);
    #1 chk("rst_pre_grant", 100, {31'd0, wr_grant}, 32'd1);
    #1 rstn = 1'b0;
    #1 chk_all(101, 2'b00, 32'h0000_0000, 32'h0100_0000, 1'b0, 1'b0, 16'd0);
    @(negedge axi_clk);
    {wr_req, wr_done, rd_req, rd_done} = 4'b0000;
    rstn = 1'b1;
    // after reset the writer is served first again at the base of buffer A
    @(negedge axi_clk) wr_req = 1'b1;
    @(posedge axi_clk);
    #1 chk_all(102, 2'b10, 32'h0000_0000, 32'h0100_0000, 1'b0, 1'b0, 16'd0);
    @(negedge axi_clk) wr_req = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
